// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_e;

  localparam int unsigned    CRC_W    = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/cfg_loader_crc16.sv
// Serial CRC-16-CCITT, MSB-first, one bit per step; clr reloads the init value.
module cfg_crc16
  import cfg_loader_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             step,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (step) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ bit_in) ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cfg_loader.sv
// Streams a word-wide bitstream MSB-first onto the serial CRAM config chain.
// Optional CRC trailer check is built when CFG_LOADER_CRC_EN is defined.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned NUM_CELLS     = 4,
  parameter int unsigned CELL_CFG_BITS = 161,
  parameter int unsigned WORD_W        = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              config_en,
  output logic              config_data_in,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int unsigned TOTAL = NUM_CELLS * CELL_CFG_BITS;
  localparam int unsigned BCW   = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [31:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BCW-1:0]    buf_cnt_q, buf_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_go;
  logic              accept;

`ifdef CFG_LOADER_CRC_EN
  logic [CRC_W-1:0]  crc_val;
  logic [CRC_W-1:0]  crc_exp_q, crc_exp_d;
  logic [4:0]        exp_cnt_q, exp_cnt_d;
  logic              crc_err_q, crc_err_d;

  cfg_crc16 u_crc (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (load_go),
    .step   (config_en),
    .bit_in (config_data_in),
    .crc    (crc_val)
  );

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign config_en      = en && (state_q == LOAD) && (buf_cnt_q != '0);
  assign config_data_in = config_en ? buf_q[WORD_W-1] : 1'b0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign accept         = s_valid && s_ready;

  // Take a word only while the chain still needs more bits than the buffer holds.
  always_comb begin
    s_ready = 1'b0;
    if (en) begin
      case (state_q)
        LOAD:    s_ready = (buf_cnt_q == '0) ||
                           ((buf_cnt_q == BCW'(1)) && (bit_cnt_q > 32'd1));
`ifdef CFG_LOADER_CRC_EN
        CHECK:   s_ready = 1'b1;
`endif
        default: s_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    load_go   = 1'b0;
`ifdef CFG_LOADER_CRC_EN
    crc_exp_d = crc_exp_q;
    exp_cnt_d = exp_cnt_q;
    crc_err_d = crc_err_q;
`endif
    if (en) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            load_go   = 1'b1;
            state_d   = LOAD;
            bit_cnt_d = TOTAL;
            buf_d     = '0;
            buf_cnt_d = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_exp_d = '0;
            exp_cnt_d = '0;
            crc_err_d = 1'b0;
`endif
          end
        end
        LOAD: begin
          if (config_en) begin
            buf_d     = buf_q << 1;
            buf_cnt_d = buf_cnt_q - BCW'(1);
            bit_cnt_d = bit_cnt_q - 32'd1;
            if (bit_cnt_q == 32'd1) begin
              buf_d     = '0;
              buf_cnt_d = '0;
`ifdef CFG_LOADER_CRC_EN
              state_d   = CHECK;
`else
              state_d   = DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
`endif
            end
          end
          // A new word lands exactly as the last buffered bit leaves.
          if (accept) begin
            buf_d     = s_data;
            buf_cnt_d = BCW'(WORD_W);
          end
        end
`ifdef CFG_LOADER_CRC_EN
        CHECK: begin
          if (accept) begin
            for (int unsigned i = 0; i < WORD_W; i++) begin
              if (exp_cnt_d < 5'(CRC_W)) begin
                crc_exp_d = {crc_exp_d[CRC_W-2:0], s_data[WORD_W-1-i]};
                exp_cnt_d = exp_cnt_d + 5'd1;
              end
            end
            if (exp_cnt_d == 5'(CRC_W)) begin
              state_d   = DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              crc_err_d = (crc_val != crc_exp_d);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
      crc_exp_q <= '0;
      exp_cnt_q <= '0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_LOADER_CRC_EN
      crc_exp_q <= crc_exp_d;
      exp_cnt_q <= exp_cnt_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: a 1-cell/8-bit loader and a 4-cell/32-bit loader.
module tb_cfg_loader;

  localparam int unsigned WA  = 8;
  localparam int unsigned TA  = 161;
  localparam int unsigned NWA = 21;
  localparam int unsigned WB  = 32;
  localparam int unsigned TB  = 644;
  localparam int unsigned NWB = 21;

`ifdef CFG_LOADER_CRC_EN
  localparam int unsigned CHK_A = 2;
  localparam int unsigned CHK_B = 1;
`else
  localparam int unsigned CHK_A = 0;
  localparam int unsigned CHK_B = 0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b1;

  logic          start_a = 1'b0, s_valid_a = 1'b0;
  logic [WA-1:0] s_data_a = '0;
  logic          s_ready_a, cfg_en_a, cfg_d_a, busy_a, done_a, crc_err_a;

  logic          start_b = 1'b0, s_valid_b = 1'b0;
  logic [WB-1:0] s_data_b = '0;
  logic          s_ready_b, cfg_en_b, cfg_d_b, busy_b, done_b, crc_err_b;

  always #5 clk = ~clk;

  cfg_loader #(.NUM_CELLS(1), .CELL_CFG_BITS(161), .WORD_W(WA)) u_dut_a (
    .clk(clk), .nrst(nrst), .en(en), .start(start_a), .s_data(s_data_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .config_en(cfg_en_a),
    .config_data_in(cfg_d_a), .busy(busy_a), .done(done_a), .crc_err(crc_err_a)
  );

  cfg_loader #(.NUM_CELLS(4), .CELL_CFG_BITS(161), .WORD_W(WB)) u_dut_b (
    .clk(clk), .nrst(nrst), .en(en), .start(start_b), .s_data(s_data_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .config_en(cfg_en_b),
    .config_data_in(cfg_d_b), .busy(busy_b), .done(done_b), .crc_err(crc_err_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [WA-1:0] wa [NWA];
  logic [WB-1:0] wb [NWB];
  logic [15:0]   crc_a, crc_b;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic exp_bit_a(input int unsigned j);
    logic [WA-1:0] w;
    w = wa[j / WA];
    return w[WA-1 - (j % WA)];
  endfunction

  function automatic logic exp_bit_b(input int unsigned j);
    logic [WB-1:0] w;
    w = wb[j / WB];
    return w[WB-1 - (j % WB)];
  endfunction

  // Observers: cycle counts and captured chain bits, sampled mid-cycle.
  int unsigned cyc = 0, busy_cyc_a = 0, cfg_cyc_a = 0, busy_cyc_b = 0, cfg_cyc_b = 0;
  bit          cap_a[$];
  int unsigned cap_cyc_a[$];

  always @(negedge clk) begin
    cyc++;
    if (busy_a) busy_cyc_a++;
    if (cfg_en_a) begin
      cfg_cyc_a++;
      cap_a.push_back(cfg_d_a);
      cap_cyc_a.push_back(cyc);
    end
    if (busy_b) busy_cyc_b++;
    if (cfg_en_b) cfg_cyc_b++;
  end

  task automatic send_word_a(input logic [WA-1:0] w, input string tag);
    bit ok = 1'b0;
    s_data_a  = w;
    s_valid_a = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (s_ready_a) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_rdy_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid_a = 1'b0;
  endtask

  task automatic send_word_b(input logic [WB-1:0] w, input string tag);
    bit ok = 1'b0;
    s_data_b  = w;
    s_valid_b = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (s_ready_b) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_rdy_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid_b = 1'b0;
  endtask

  task automatic load_a(input int stall_at, input int en_off_at, input int start_at,
                        input bit flip, input string tag);
    int unsigned base, busy0, cfg0, c0, n, gaps, mism, extra;
    bit ok;
    logic [15:0] trailer;
    base  = cap_a.size();
    busy0 = busy_cyc_a;
    cfg0  = cfg_cyc_a;
    extra = 0;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int i = 0; i < NWA; i++) begin
      if (i == stall_at) begin
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
          @(negedge clk);
          if (s_ready_a) begin ok = 1'b1; break; end
        end
        if (!ok) chk({tag, "_stall_timeout"}, 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        extra += 5;
      end
      if (i == en_off_at) begin
        c0 = cfg_cyc_a;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({tag, "_en_off_outs"}, {62'd0, cfg_en_a, s_ready_a}, 64'd0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        chk({tag, "_en_off_frozen"}, 64'(cfg_cyc_a - c0), 64'd0);
        extra += 3;
      end
      if (i == start_at) begin
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
      end
      send_word_a(wa[i], tag);
    end
`ifdef CFG_LOADER_CRC_EN
    trailer = crc_a ^ {15'd0, flip};
    send_word_a(trailer[15:8], tag);
    send_word_a(trailer[7:0], tag);
`else
    trailer = 16'h0;
`endif
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    n = cfg_cyc_a - cfg0;
    chk({tag, "_cfg_cycles"}, 64'(n), 64'(TA));
    gaps = 999;
    if (n > 0) gaps = cap_cyc_a[base + n - 1] - cap_cyc_a[base] + 1 - n;
    chk({tag, "_gap_cycles"}, 64'(gaps), 64'(en_off_at >= 0 ? 3 : (stall_at >= 0 ? 5 : 0)));
    mism = 0;
    for (int unsigned j = 0; j < TA; j++) begin
      if (base + j >= cap_a.size()) mism++;
      else if (cap_a[base + j] !== exp_bit_a(j)) mism++;
    end
    chk({tag, "_chain_bits"}, 64'(mism), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc_a - busy0), 64'(1 + TA + CHK_A + extra));
`ifdef CFG_LOADER_CRC_EN
    chk({tag, "_flags"}, {58'd0, done_a, busy_a, crc_err_a, s_ready_a, cfg_en_a, cfg_d_a},
        {58'd0, 1'b1, 1'b0, flip, 3'b000});
`else
    chk({tag, "_flags"}, {58'd0, done_a, busy_a, crc_err_a, s_ready_a, cfg_en_a, cfg_d_a},
        {58'd0, 6'b100000});
`endif
  endtask

  task automatic load_b(input string tag);
    int unsigned busy0, cfg0;
    bit ok;
    busy0 = busy_cyc_b;
    cfg0  = cfg_cyc_b;
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    for (int i = 0; i < NWB; i++) send_word_b(wb[i], tag);
`ifdef CFG_LOADER_CRC_EN
    send_word_b({crc_b, 16'h0000}, tag);
`endif
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_cfg_cycles"}, 64'(cfg_cyc_b - cfg0), 64'(TB));
    chk({tag, "_busy_cycles"}, 64'(busy_cyc_b - busy0), 64'(1 + TB + CHK_B));
    chk({tag, "_flags"}, {61'd0, done_b, busy_b, crc_err_b}, {61'd0, 3'b100});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < NWA; i++) wa[i] = 8'(i * 37 + 11);
    for (int i = 0; i < NWB; i++) wb[i] = {wa[i], ~wa[i], wa[(i + 1) % NWA], 8'h5A ^ wa[i]};
    crc_a = 16'hFFFF;
    for (int unsigned j = 0; j < TA; j++) crc_a = crc_step(crc_a, exp_bit_a(j));
    crc_b = 16'hFFFF;
    for (int unsigned j = 0; j < TB; j++) crc_b = crc_step(crc_b, exp_bit_b(j));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_a", {58'd0, s_ready_a, cfg_en_a, cfg_d_a, busy_a, done_a, crc_err_a}, 64'd0);
    chk("reset_outs_b", {58'd0, s_ready_b, cfg_en_b, cfg_d_b, busy_b, done_b, crc_err_b}, 64'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    s_valid_a = 1'b1;
    s_data_a  = 8'hFF;
    @(negedge clk);
    chk("idle_outs", {59'd0, s_ready_a, cfg_en_a, cfg_d_a, busy_a, done_a}, 64'd0);
    @(posedge clk); #1;
    s_valid_a = 1'b0;

    load_a(-1, -1, -1, 1'b0, "a_cont");
    load_a(10, -1, -1, 1'b0, "a_stall");
    load_a(-1, 6, 12, 1'b0, "a_en_start");
`ifdef CFG_LOADER_CRC_EN
    load_a(-1, -1, -1, 1'b1, "a_crc_bad");
`endif

    // Abort a load after 50 bits with an asynchronous reset.
    begin
      int unsigned cfg0;
      cfg0 = cfg_cyc_a;
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int i = 0; i < 7; i++) send_word_a(wa[i], "a_abort");
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (cfg_cyc_a - cfg0 >= 50) begin ok = 1'b1; break; end
      end
      chk("a_abort_50_bits", 64'(ok), 64'd1);
      chk("a_abort_pre_busy", {63'd0, busy_a}, 64'd1);
      nrst = 1'b0;
      #1;
      chk("a_abort_outs", {58'd0, s_ready_a, cfg_en_a, cfg_d_a, busy_a, done_a, crc_err_a}, 64'd0);
      @(posedge clk); #1;
      nrst = 1'b1;
    end
    load_a(-1, -1, -1, 1'b0, "a_after_rst");

    load_b("b_first");
    load_b("b_reload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
